// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings and constants for the multiply/divide unit.
`default_nettype none

package mdu_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_e;

   localparam logic [31:0] DIV0_LO    = 32'hFFFF_FFFF;
   localparam int          ITER_COUNT = 32;

endpackage

`default_nettype wire

// File: rtl/mdu_shift_core.sv
// mdu_shift_core: one iteration of shift-add multiply or restoring divide.
`default_nettype none

module mdu_shift_core (
   input  logic        is_div,
   input  logic [31:0] acc_hi,
   input  logic [31:0] acc_lo,
   input  logic [31:0] operand,
   output logic [31:0] next_hi,
   output logic [31:0] next_lo
);

   logic [32:0] sum;
   logic [32:0] shifted;
   logic [31:0] diff;

   always_comb begin
      sum     = {1'b0, acc_hi} + {1'b0, operand};
      shifted = {acc_hi, acc_lo[31]};
      // Remainder stays below the divisor, so the low 32 bits hold the exact difference.
      diff    = shifted[31:0] - operand;
      next_hi = acc_hi;
      next_lo = acc_lo;
      if (is_div) begin
         if (shifted >= {1'b0, operand}) begin
            next_hi = diff;
            next_lo = {acc_lo[30:0], 1'b1};
         end else begin
            next_hi = shifted[31:0];
            next_lo = {acc_lo[30:0], 1'b0};
         end
      end else if (acc_lo[0]) begin
         next_hi = sum[32:1];
         next_lo = {sum[0], acc_lo[31:1]};
      end else begin
         next_hi = {1'b0, acc_hi[31:1]};
         next_lo = {acc_hi[0], acc_lo[31:1]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO registers.
// Define MDU_FAST_MUL_EN to compile in a single-cycle multiplier.
`default_nettype none

module mul_div_unit
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   state_e      state, state_next;
   logic [4:0]  count;
   logic [31:0] acc_hi, acc_lo, operand_q, dividend_q;
   logic        is_div_q, neg_q, rem_neg_q, div0_q;
   logic [31:0] step_hi, step_lo;

   op_e         op_in;
   logic        accept, accept_iter, fast_mul;
   logic        is_signed, a_neg, b_neg;
   logic [31:0] mag_a, mag_b;
   logic [63:0] prod_fix;
   logic [31:0] q_fix, r_fix, res_hi, res_lo;

   assign op_in     = op_e'(op);
   assign busy      = (state != S_IDLE);
   assign accept    = start & ~busy;
   assign is_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
   assign a_neg     = is_signed & rs_data[31];
   assign b_neg     = is_signed & rt_data[31];
   assign mag_a     = a_neg ? -rs_data : rs_data;
   assign mag_b     = b_neg ? -rt_data : rt_data;

`ifdef MDU_FAST_MUL_EN
   logic [63:0] ext_a, ext_b, fast_prod;
   assign ext_a     = {{32{a_neg}}, rs_data};
   assign ext_b     = {{32{b_neg}}, rt_data};
   assign fast_prod = ext_a * ext_b;
   assign fast_mul  = accept & ~op[1];
`else
   assign fast_mul  = 1'b0;
`endif

   assign accept_iter = accept & ~fast_mul;

   mdu_shift_core u_core (
      .is_div  (is_div_q),
      .acc_hi  (acc_hi),
      .acc_lo  (acc_lo),
      .operand (operand_q),
      .next_hi (step_hi),
      .next_lo (step_lo)
   );

   // Sign correction applied on the FIX cycle.
   always_comb begin
      prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      q_fix    = neg_q ? -acc_lo : acc_lo;
      r_fix    = rem_neg_q ? -acc_hi : acc_hi;
      res_hi   = prod_fix[63:32];
      res_lo   = prod_fix[31:0];
      if (is_div_q) begin
         if (div0_q) begin
            res_hi = dividend_q;
            res_lo = DIV0_LO;
         end else begin
            res_hi = r_fix;
            res_lo = q_fix;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (accept_iter) state_next = S_CALC;
         S_CALC:  if (count == 5'd0) state_next = S_FIX;
         S_FIX:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= 5'd0;
         acc_hi     <= 32'd0;
         acc_lo     <= 32'd0;
         operand_q  <= 32'd0;
         dividend_q <= 32'd0;
         is_div_q   <= 1'b0;
         neg_q      <= 1'b0;
         rem_neg_q  <= 1'b0;
         div0_q     <= 1'b0;
         done       <= 1'b0;
         hi         <= 32'd0;
         lo         <= 32'd0;
      end else begin
         done <= 1'b0;
         if (!busy && hi_we) hi <= wr_data;
         if (!busy && lo_we) lo <= wr_data;
         case (state)
            S_IDLE: begin
               if (accept_iter) begin
                  count      <= 5'(ITER_COUNT - 1);
                  acc_hi     <= 32'd0;
                  acc_lo     <= mag_a;
                  operand_q  <= mag_b;
                  dividend_q <= rs_data;
                  is_div_q   <= op[1];
                  neg_q      <= a_neg ^ b_neg;
                  rem_neg_q  <= a_neg;
                  div0_q     <= (rt_data == 32'd0);
               end
`ifdef MDU_FAST_MUL_EN
               // Result write placed after direct writes so it wins on a shared edge.
               if (fast_mul) begin
                  hi   <= fast_prod[63:32];
                  lo   <= fast_prod[31:0];
                  done <= 1'b1;
               end
`endif
            end
            S_CALC: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               count  <= count - 5'd1;
            end
            S_FIX: begin
               hi   <= res_hi;
               lo   <= res_lo;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: table, random and corner-sequence checks for mul_div_unit.
`default_nettype none

module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst, start, hi_we, lo_we;
   logic [1:0]  op;
   logic [31:0] rs_data, rt_data, wr_data;
   logic        busy, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   mul_div_unit dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .rs_data(rs_data), .rt_data(rt_data),
      .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b, hi, lo;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   function automatic int exp_latency(input logic [1:0] o);
`ifdef MDU_FAST_MUL_EN
      return o[1] ? 34 : 1;
`else
      return (o == 2'b00) ? 34 : 34;
`endif
   endfunction

   // Reference model straight from the arithmetic definition; returns {hi, lo}.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'b00: begin p = 64'(sa * sb); return p; end
         2'b01: return {32'd0, a} * {32'd0, b};
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (o == 2'b10) begin
               q = sa / sb;
               r = sa % sb;
               return {r[31:0], q[31:0]};
            end
            return {a % b, a / b};
         end
      endcase
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input string nm);
      int lat, got, ndone;
      lat = exp_latency(o);
      got = -1;
      ndone = 0;
      @(negedge clk);
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      for (int c = 1; c <= lat + 3; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 1) check({nm, " busy"}, 64'(busy), 64'(lat != 1));
         if (done) begin
            ndone++;
            if (got < 0) begin
               got = c;
               check({nm, " hi"}, 64'(hi), 64'(eh));
               check({nm, " lo"}, 64'(lo), 64'(el));
            end
         end
      end
      check({nm, " latency"}, 64'(got), 64'(lat));
      check({nm, " done_pulses"}, 64'(ndone), 64'd1);
   endtask

   initial begin
      logic [63:0] e;
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int got, ndone;

      vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
      vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
      vecs[4] = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
      vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
      vecs[6] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
      vecs[8] = '{2'b10, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF};

      rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op = 2'b00; rs_data = '0; rt_data = '0; wr_data = '0;
      repeat (3) @(negedge clk);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset hi", 64'(hi), 64'd0);
      check("reset lo", 64'(lo), 64'd0);
      rst = 1'b0;

      // Direct writes while idle.
      hi_we = 1'b1; wr_data = 32'h1234_5678;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b1; wr_data = 32'h9ABC_DEF0;
      @(negedge clk);
      lo_we = 1'b0;
      check("mthi", 64'(hi), 64'h1234_5678);
      check("mtlo", 64'(lo), 64'h9ABC_DEF0);

      for (int i = 0; i < 9; i++)
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

      for (int i = 0; i < 20; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = (i % 5 == 0) ? 32'd0 : (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
         if (i % 7 == 0) rb = -rb;
         e = model(ro, ra, rb);
         run_op(ro, ra, rb, e[63:32], e[31:0], $sformatf("rnd%0d", i));
      end

      // Start and MTLO while busy must be ignored.
      @(negedge clk);
      start = 1'b1; op = 2'b11; rs_data = 32'd100; rt_data = 32'd7;
      got = -1; ndone = 0;
      for (int c = 1; c <= 38; c++) begin
         @(negedge clk);
         start = 1'b0; lo_we = 1'b0;
         if (c == 10) begin start = 1'b1; rs_data = 32'd50; rt_data = 32'd3; end
         if (c == 12) begin lo_we = 1'b1; wr_data = 32'hDEAD_BEEF; end
         if (done) begin
            ndone++;
            if (got < 0) begin
               got = c;
               check("busy_ign hi", 64'(hi), 64'd2);
               check("busy_ign lo", 64'(lo), 64'd14);
            end
         end
      end
      start = 1'b0; lo_we = 1'b0;
      check("busy_ign latency", 64'(got), 64'd34);
      check("busy_ign done_pulses", 64'(ndone), 64'd1);
      check("busy_ign idle", 64'(busy), 64'd0);

      // Reset in the middle of a divide aborts it.
      @(negedge clk);
      start = 1'b1; op = 2'b10; rs_data = 32'd1000; rt_data = 32'd3;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort busy", 64'(busy), 64'd0);
      check("abort done", 64'(done), 64'd0);
      check("abort hi", 64'(hi), 64'd0);
      check("abort lo", 64'(lo), 64'd0);
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abort no_done", 64'(ndone), 64'd0);
      check("abort lo_held", 64'(lo), 64'd0);
      run_op(2'b10, 32'd1000, 32'd3, 32'd1, 32'd333, "after_abort");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameters: none; datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin operation op on rs_data/rt_data.
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 rs_data  input  32  operand A / dividend, driven from register-file read_data1.
REQ-007 rt_data  input  32  operand B / divisor, driven from register-file read_data2.
REQ-008 hi_we  input  1  MTHI direct write of wr_data into HI.
REQ-009 lo_we  input  1  MTLO direct write of wr_data into LO.
REQ-010 wr_data  input  32  direct-write data.
REQ-011 busy  output  1  operation in progress; start is ignored while high.
REQ-012 done  output  1  one-cycle pulse; HI/LO hold a new result.
REQ-013 hi  output  32  HI register: product upper word or remainder.
REQ-014 lo  output  32  LO register: product lower word or quotient.

Function
REQ-015 Start is accepted on an edge where start=1 and busy=0; operands and op are latched on that edge.
REQ-016 FSM states are IDLE, CALC and FIX.
- IDLE->CALC on accepted start; the 5-bit counter loads 31.
- CALC decrements the counter once per cycle; CALC->FIX when the counter is 0.
- FIX->IDLE.
REQ-017 Signed ops convert operands to magnitudes on accept; FIX applies sign correction.
- Product is negated if operand signs differ.
- Quotient is negated if signs differ.
- Remainder takes the dividend's sign.
REQ-018 Multiply is iterative shift-add (one bit per CALC cycle) producing a 64-bit product: HI=product[63:32], LO=product[31:0].
REQ-019 Divide is iterative restoring division (one quotient bit per CALC cycle): quotient truncated toward zero.
REQ-020 Latency: start in cycle 0, busy=1 in cycles 1-33, HI/LO written on the FIX edge, done=1 and busy=0 in cycle 34.
REQ-021 A start while busy=1 is ignored and has no side effects.
REQ-022 Divide by zero completes with normal latency: LO=0xFFFFFFFF, HI=dividend (rs_data).
REQ-023 DIV 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0 with no exception.
REQ-024 hi_we/lo_we take effect only when busy=0; they are ignored while busy=1.
REQ-025 If a direct write and a result write occur on the same edge, the result write wins.
REQ-026 hi and lo hold their value between writes; done is 0 in every cycle except the one defined completion cycle.

Reset
REQ-027 rst=1 at an edge forces the following: state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0.
REQ-028 rst asserted mid-operation aborts it with no result write; the next start after rst deasserts runs normally.

Configuration
REQ-029 Macro MDU_FAST_MUL_EN, when defined, compiles in a single-cycle 32x32 multiplier.
- MULT/MULTU write HI/LO on the accept edge, with done=1 in cycle 1 and busy never asserted.
- Divide timing is unchanged.
REQ-030 When MDU_FAST_MUL_EN is undefined, multiply uses the iterative path with 34-cycle latency per REQ-020.

Structure
REQ-031 Package mdu_pkg holds the op encoding enum, the FSM state enum, the DIV0_LO constant (0xFFFFFFFF) and the iteration count constant (32).
REQ-032 Sub-module mdu_shift_core holds the per-cycle shift-add/restoring-subtract datapath.
- mul_div_unit holds the FSM, counter, sign handling and the HI/LO registers.

Verification
REQ-033 MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, done in cycle 34 (cycle 1 with MDU_FAST_MUL_EN).
REQ-034 MULT -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-035 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/7 -> LO=14, HI=2.
REQ-036 DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
- DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-037 Start a divide, pulse start with different operands in cycle 10, pulse lo_we in cycle 12 -> both ignored; the original result appears in cycle 34.
REQ-038 Assert rst in cycle 15 of a divide -> busy=0, done=0, hi=lo=0 on the next cycle, and no done pulse later.
